// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data and pointer-derived full/empty flags.
// Pointers carry one extra wrap bit so a full FIFO and an empty FIFO can be told apart.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  // Both handshakes are judged against the flags as they stood before the edge.
  assign wr_en = write & ~full;
  assign rd_en = read & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      data_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
    end
  end

  // Storage is left uncleared by reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed stimulus for sync_fifo, checked every cycle against a queue model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_dout = '0;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .write   (write),
    .read    (read),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: occupancy and order come straight from a queue.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
      exp_dout = '0;
    end else begin
      bit acc_w, acc_r;
      acc_w = write && (model_q.size() < DEPTH);
      acc_r = read && (model_q.size() > 0);
      if (acc_r) exp_dout = model_q.pop_front();
      if (acc_w) model_q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("data_out", 32'(data_out), 32'(exp_dout));
      chk("empty", 32'(empty), 32'(model_q.size() == 0));
      chk("full", 32'(full), 32'(model_q.size() == DEPTH));
      chk("not_both", 32'(full & empty), 32'd0);
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [DW-1:0] d);
    @(negedge clk);
    write   = w;
    read    = r;
    data_in = d;
    @(posedge clk);
    #1;
    $display("txn w=%0b r=%0b din=%02h -> dout=%02h empty=%0b full=%0b",
             w, r, d, data_out, empty, full);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] next_val;

    #2 reset = 1'b0;
    armed = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic order
    cyc(1, 0, 8'hA5);
    chk("first_wr_empty", 32'(empty), 32'd0);
    cyc(1, 0, 8'h3C);
    cyc(1, 0, 8'h7E);
    chk("three_full", 32'(full), 32'd0);
    cyc(0, 1, 8'h00); chk("rd0", 32'(data_out), 32'hA5);
    cyc(0, 1, 8'h00); chk("rd1", 32'(data_out), 32'h3C);
    cyc(0, 1, 8'h00); chk("rd2", 32'(data_out), 32'h7E);
    chk("drained_empty", 32'(empty), 32'd1);

    // Underflow
    cyc(0, 1, 8'h00);
    chk("underflow_dout", 32'(data_out), 32'h7E);
    chk("underflow_empty", 32'(empty), 32'd1);
    cyc(1, 0, 8'h11);
    cyc(0, 1, 8'h00);
    chk("after_underflow", 32'(data_out), 32'h11);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) cyc(1, 0, DW'(i));
    chk("fill_full", 32'(full), 32'd1);
    cyc(1, 0, 8'h05);
    chk("overflow_full", 32'(full), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 8'h00);
      chk("fill_rd", 32'(data_out), 32'(i));
    end
    chk("fill_drained", 32'(empty), 32'd1);

    // Simultaneous with two stored
    cyc(1, 0, 8'h20);
    cyc(1, 0, 8'h21);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, DW'(8'h22 + i));
      chk("simul_rd", 32'(data_out), 32'(8'h20 + i));
    end
    chk("simul_empty", 32'(empty), 32'd0);
    chk("simul_full", 32'(full), 32'd0);
    cyc(0, 1, 8'h00); chk("simul_tail0", 32'(data_out), 32'h23);
    cyc(0, 1, 8'h00); chk("simul_tail1", 32'(data_out), 32'h24);

    // Simultaneous while empty: write only, no fall-through
    cyc(1, 1, 8'h30);
    chk("empty_simul_dout", 32'(data_out), 32'h24);
    chk("empty_simul_empty", 32'(empty), 32'd0);
    cyc(0, 1, 8'h00); chk("empty_simul_rd", 32'(data_out), 32'h30);

    // Simultaneous while full: read only
    for (int i = 0; i < 4; i++) cyc(1, 0, DW'(8'h40 + i));
    cyc(1, 1, 8'h44);
    chk("full_simul_dout", 32'(data_out), 32'h40);
    chk("full_simul_full", 32'(full), 32'd0);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 1, 8'h00);
      chk("full_simul_rd", 32'(data_out), 32'(8'h40 + i));
    end
    chk("full_simul_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-stream
    cyc(1, 0, 8'h50);
    cyc(1, 0, 8'h51);
    cyc(0, 1, 8'h00);
    chk("pre_rst_dout", 32'(data_out), 32'h50);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_dout", 32'(data_out), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full", 32'(full), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Wrap-around: fill/drain rounds of mixed length
    next_val = 8'h60;
    for (int round = 0; round < 10; round++) begin
      int nw, nr;
      nw = $urandom_range(1, DEPTH + 2);
      nr = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < nw; i++) begin
        cyc(1, 0, next_val);
        next_val++;
      end
      for (int i = 0; i < nr; i++) cyc(0, 1, 8'h00);
    end

    // Random mixed traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom), 1'($urandom), 8'($urandom));
    end

    @(negedge clk);
    armed = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
